// File: rtl/mdio_xact_ctrl_if.sv
// rtl/mdio_xact_ctrl_if.sv - request/response, MDC strobe and MDIO pad bundle
interface mdio_xact_ctrl_if;
  logic        mdc_rise_stb;
  logic        mdc_fall_stb;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_phy_addr;
  logic [4:0]  req_reg_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        mdio_out;
  logic        mdio_tri;
  logic        mdio_in;

  modport master (
    output mdc_rise_stb, mdc_fall_stb, req_valid, req_write, req_phy_addr,
           req_reg_addr, req_wdata, mdio_in,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mdio_out, mdio_tri
  );

  modport slave (
    input  mdc_rise_stb, mdc_fall_stb, req_valid, req_write, req_phy_addr,
           req_reg_addr, req_wdata, mdio_in,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mdio_out, mdio_tri
  );
endinterface

// File: rtl/mdio_xact_ctrl.sv
// rtl/mdio_xact_ctrl.sv - clause-22 MDIO frame serialiser with read-back sampling
module mdio_xact_ctrl #(
  parameter int PREAMBLE_LEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  mdio_xact_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PRE, S_FRAME} state_t;

  localparam logic [4:0] PRE_LAST   = 5'(PREAMBLE_LEN - 1);
  localparam logic [4:0] FRAME_LAST = 5'd31;
  localparam logic [4:0] TA_BIT     = 5'd14;
  localparam logic [4:0] ERR_BIT    = 5'd15;
  localparam logic [4:0] DATA_BIT0  = 5'd16;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic        r_out, w_out_nxt;
  logic        r_tri, w_tri_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic        r_write;
  logic [4:0]  r_phy;
  logic [4:0]  r_reg;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_fall;
  logic        w_rise;
  logic [31:0] w_frame;
  logic [4:0]  w_bit_nxt;

  // A coincident fall wins: the bit advances and the rise sample is dropped.
  assign w_fall    = bus.mdc_fall_stb;
  assign w_rise    = bus.mdc_rise_stb & ~bus.mdc_fall_stb;
  assign bus.req_ready = (r_state == S_IDLE) & reset;
  assign w_accept  = bus.req_valid & bus.req_ready;
  assign w_bit_nxt = r_cnt + 5'd1;
  assign w_frame   = {2'b01, (r_write ? 2'b01 : 2'b10), r_phy, r_reg,
                      (r_write ? {2'b10, r_wdata} : 18'h0)};

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign bus.mdio_out  = r_out;
  assign bus.mdio_tri  = r_tri;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 5'd0;
      r_out       <= 1'b0;
      r_tri       <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out       <= w_out_nxt;
      r_tri       <= w_tri_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_out_nxt       = r_out;
    w_tri_nxt       = r_tri;
    w_rsp_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_fall) begin
          w_out_nxt   = 1'b1;
          w_tri_nxt   = 1'b1;
          w_cnt_nxt   = 5'd0;
          w_state_nxt = S_PRE;
        end
      end
      S_PRE: begin
        if (w_fall) begin
          if (r_cnt == PRE_LAST) begin
            w_out_nxt   = w_frame[31];
            w_tri_nxt   = 1'b1;
            w_cnt_nxt   = 5'd0;
            w_state_nxt = S_FRAME;
          end else begin
            w_cnt_nxt = w_bit_nxt;
          end
        end
      end
      S_FRAME: begin
        if (w_fall) begin
          if (r_cnt == FRAME_LAST) begin
            w_out_nxt       = 1'b0;
            w_tri_nxt       = 1'b0;
            w_cnt_nxt       = 5'd0;
            w_state_nxt     = S_IDLE;
            w_rsp_valid_nxt = 1'b1;
          end else begin
            w_cnt_nxt = w_bit_nxt;
            // Reads hand the pad to the PHY from the first TA bit onward.
            if (!r_write && (w_bit_nxt >= TA_BIT)) begin
              w_out_nxt = 1'b0;
              w_tri_nxt = 1'b0;
            end else begin
              w_out_nxt = w_frame[5'd31 - w_bit_nxt];
              w_tri_nxt = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write <= 1'b0;
      r_phy   <= 5'd0;
      r_reg   <= 5'd0;
      r_wdata <= 16'h0;
      r_rdata <= 16'h0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= bus.req_write;
        r_phy   <= bus.req_phy_addr;
        r_reg   <= bus.req_reg_addr;
        r_wdata <= bus.req_wdata;
        if (bus.req_write) begin
          r_rdata <= 16'h0;
          r_err   <= 1'b0;
        end
      end
      if ((r_state == S_FRAME) && !r_write && w_rise) begin
        if (r_cnt == ERR_BIT) begin
          r_err <= bus.mdio_in;
        end else if (r_cnt >= DATA_BIT0) begin
          r_rdata <= {r_rdata[14:0], bus.mdio_in};
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_xact_ctrl.sv
// tb/tb_mdio_xact_ctrl.sv - directed self-checking bench for mdio_xact_ctrl
`timescale 1ns/1ps
module tb_mdio_xact_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdio_xact_ctrl_if bus0 ();
  mdio_xact_ctrl_if bus1 ();

  mdio_xact_ctrl #(.PREAMBLE_LEN(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  mdio_xact_ctrl #(.PREAMBLE_LEN(1)) u_dut_p1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MDC model: 8 clk period, rise strobe at phase 0, fall strobe at phase 4.
  int          phase = 7;
  int          bitn0 = -1;
  int          gap0 = 0;
  int          fb;
  logic [63:0] cap_out0 = '0;
  logic [63:0] cap_tri0 = '0;
  logic [63:0] fr_out_q[$];
  logic [63:0] fr_tri_q[$];
  int          gap_q[$];
  logic        phy_present = 1'b0;
  logic [15:0] phy_data = 16'h0;
  int          len1 = 0;
  logic [63:0] cap_out1 = '0;
  int          len1_q[$];
  logic [63:0] out1_q[$];
  int          rsp_cnt0 = 0;
  int          rsp_cnt1 = 0;

  always @(negedge clk) begin
    phase = (phase + 1) % 8;
    bus0.mdc_rise_stb = (phase == 0);
    bus0.mdc_fall_stb = (phase == 4);
    bus1.mdc_rise_stb = (phase == 0);
    bus1.mdc_fall_stb = (phase == 4);
    if (bus0.rsp_valid) rsp_cnt0++;
    if (bus1.rsp_valid) rsp_cnt1++;
    if (!reset) begin
      bitn0    = -1;
      gap0     = 0;
      cap_out0 = '0;
      cap_tri0 = '0;
      len1     = 0;
      cap_out1 = '0;
    end else if (phase == 0) begin
      if (bitn0 < 0 && bus0.mdio_tri) begin
        bitn0 = 0;
        gap_q.push_back(gap0);
        gap0 = 0;
      end
      if (bitn0 >= 0) begin
        cap_out0 = {cap_out0[62:0], bus0.mdio_out};
        cap_tri0 = {cap_tri0[62:0], bus0.mdio_tri};
        fb = bitn0 - 32;
        if (phy_present && fb >= 15 && fb <= 31)
          bus0.mdio_in = (fb == 15) ? 1'b0 : phy_data[31 - fb];
        else
          bus0.mdio_in = 1'b1;
        bitn0++;
        if (bitn0 == 64) begin
          fr_out_q.push_back(cap_out0);
          fr_tri_q.push_back(cap_tri0);
          bitn0 = -1;
        end
      end else begin
        gap0++;
        bus0.mdio_in = 1'b1;
      end
      if (bus1.mdio_tri) begin
        cap_out1 = {cap_out1[62:0], bus1.mdio_out};
        len1++;
      end else if (len1 > 0) begin
        len1_q.push_back(len1);
        out1_q.push_back(cap_out1);
        len1     = 0;
        cap_out1 = '0;
      end
    end
  end

  task automatic send0(input logic w, input logic [4:0] p, input logic [4:0] r, input logic [15:0] d);
    int n = 0;
    bus0.req_valid    = 1'b1;
    bus0.req_write    = w;
    bus0.req_phy_addr = p;
    bus0.req_reg_addr = r;
    bus0.req_wdata    = d;
    while (!bus0.req_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("req0_accept", bus0.req_ready, 1'b1);
    @(negedge clk);
    bus0.req_valid = 1'b0;
  endtask

  task automatic wait_rsp0(input int target);
    int n = 0;
    while (rsp_cnt0 < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("rsp0_done", rsp_cnt0 >= target, 1'b1);
    repeat (16) @(negedge clk);
  endtask

  int c;
  int n;
  int g;

  initial begin
    reset = 1'b0;
    bus0.mdc_rise_stb = 1'b0; bus0.mdc_fall_stb = 1'b0;
    bus1.mdc_rise_stb = 1'b0; bus1.mdc_fall_stb = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_phy_addr = '0;
    bus0.req_reg_addr = '0; bus0.req_wdata = '0; bus0.mdio_in = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_phy_addr = '0;
    bus1.req_reg_addr = '0; bus1.req_wdata = '0; bus1.mdio_in = 1'b1;

    repeat (3) @(negedge clk);
    check_eq("rst_ready", bus0.req_ready, 1'b0);
    check_eq("rst_rsp_valid", bus0.rsp_valid, 1'b0);
    check_eq("rst_rdata", bus0.rsp_rdata, 16'h0);
    check_eq("rst_err", bus0.rsp_err, 1'b0);
    check_eq("rst_tri", bus0.mdio_tri, 1'b0);
    check_eq("rst_out", bus0.mdio_out, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", bus0.req_ready, 1'b1);

    // Write phy=1 reg=0 data=0x1140
    c = rsp_cnt0;
    send0(1'b1, 5'd1, 5'd0, 16'h1140);
    wait_rsp0(c + 1);
    check_eq("wr_out", fr_out_q.pop_front(), {32'hFFFF_FFFF, 32'h5082_1140});
    check_eq("wr_tri", fr_tri_q.pop_front(), 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("wr_rsp_cnt", rsp_cnt0, c + 1);
    check_eq("wr_err", bus0.rsp_err, 1'b0);
    check_eq("wr_rdata", bus0.rsp_rdata, 16'h0);

    // Read phy=5 reg=2, PHY returns 0x0141
    phy_present = 1'b1;
    phy_data    = 16'h0141;
    c = rsp_cnt0;
    send0(1'b0, 5'd5, 5'd2, 16'hDEAD);
    wait_rsp0(c + 1);
    check_eq("rd_out", fr_out_q.pop_front(), {32'hFFFF_FFFF, 32'h6288_0000});
    check_eq("rd_tri", fr_tri_q.pop_front(), {32'hFFFF_FFFF, 32'hFFFC_0000});
    check_eq("rd_rdata", bus0.rsp_rdata, 16'h0141);
    check_eq("rd_err", bus0.rsp_err, 1'b0);

    // Read with no PHY: pad pulled high
    phy_present = 1'b0;
    c = rsp_cnt0;
    send0(1'b0, 5'd3, 5'd1, 16'h0);
    wait_rsp0(c + 1);
    check_eq("nophy_out", fr_out_q.pop_front(), {32'hFFFF_FFFF, 32'h6184_0000});
    void'(fr_tri_q.pop_front());
    check_eq("nophy_rdata", bus0.rsp_rdata, 16'hFFFF);
    check_eq("nophy_err", bus0.rsp_err, 1'b1);
    check_eq("nophy_rsp_cnt", rsp_cnt0, c + 1);

    // Back-to-back write then read with req_valid held high
    phy_present = 1'b1;
    phy_data    = 16'hBEEF;
    gap_q.delete();
    c = rsp_cnt0;
    bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_phy_addr = 5'd7;
    bus0.req_reg_addr = 5'd9; bus0.req_wdata = 16'h1234;
    n = 0;
    while (!bus0.req_ready && n < 3000) begin @(negedge clk); n++; end
    check_eq("b2b_first_accept", bus0.req_ready, 1'b1);
    @(negedge clk);
    bus0.req_write = 1'b0;
    n = 0;
    while (!bus0.req_ready && n < 3000) begin @(negedge clk); n++; end
    check_eq("b2b_accept_on_rsp", bus0.rsp_valid, 1'b1);
    @(negedge clk);
    bus0.req_valid = 1'b0;
    wait_rsp0(c + 2);
    check_eq("b2b_wr_out", fr_out_q.pop_front(), {32'hFFFF_FFFF, 32'h53A6_1234});
    void'(fr_tri_q.pop_front());
    check_eq("b2b_rd_out", fr_out_q.pop_front(), {32'hFFFF_FFFF, 32'h63A4_0000});
    check_eq("b2b_rd_tri", fr_tri_q.pop_front(), {32'hFFFF_FFFF, 32'hFFFC_0000});
    void'(gap_q.pop_front());
    g = gap_q.pop_front();
    check_eq("b2b_gap", g, 1);
    check_eq("b2b_rdata", bus0.rsp_rdata, 16'hBEEF);
    check_eq("b2b_rsp_cnt", rsp_cnt0, c + 2);

    // Reset during frame bit 20 of a read
    phy_data = 16'h5555;
    c = rsp_cnt0;
    send0(1'b0, 5'd2, 5'd4, 16'h0);
    n = 0;
    while (bitn0 < 53 && n < 3000) begin @(negedge clk); n++; end
    check_eq("mid_reached_bit20", bitn0 >= 53, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_tri", bus0.mdio_tri, 1'b0);
    check_eq("mid_rst_out", bus0.mdio_out, 1'b0);
    check_eq("mid_rst_ready", bus0.req_ready, 1'b0);
    check_eq("mid_rst_rdata", bus0.rsp_rdata, 16'h0);
    check_eq("mid_rst_rsp_valid", bus0.rsp_valid, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (200) @(negedge clk);
    check_eq("mid_no_rsp", rsp_cnt0, c);
    send0(1'b1, 5'd4, 5'd16, 16'h00FF);
    wait_rsp0(c + 1);
    check_eq("post_rst_wr_out", fr_out_q.pop_front(), {32'hFFFF_FFFF, 32'h5242_00FF});
    check_eq("post_rst_wr_tri", fr_tri_q.pop_front(), 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("post_rst_rsp_cnt", rsp_cnt0, c + 1);

    // PREAMBLE_LEN=1 instance: write phy=2 reg=3 data=0xA5A5
    c = rsp_cnt1;
    bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_phy_addr = 5'd2;
    bus1.req_reg_addr = 5'd3; bus1.req_wdata = 16'hA5A5;
    n = 0;
    while (!bus1.req_ready && n < 3000) begin @(negedge clk); n++; end
    check_eq("p1_accept", bus1.req_ready, 1'b1);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    n = 0;
    while (rsp_cnt1 < c + 1 && n < 3000) begin @(negedge clk); n++; end
    check_eq("p1_rsp_cnt", rsp_cnt1, c + 1);
    repeat (16) @(negedge clk);
    check_eq("p1_len", len1_q.pop_front(), 33);
    check_eq("p1_out", out1_q.pop_front(), 64'h1_510E_A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdio_xact_ctrl.md
Name: mdio_xact_ctrl

Overview:
- MDIO transaction controller that sits directly upstream of the station-management MDC/shift stage.
- Accepts single PHY register read/write requests on a valid/ready interface and serialises the full IEEE 802.3 clause-22 frame onto mdio_out/mdio_tri. Timing comes from the MDC rise/fall strobes produced by that stage.
- For reads, samples mdio_in and returns the 16-bit register value plus a turnaround error flag on a response port.

Parameters:
PREAMBLE_LEN, 32, number of preamble '1' bits sent before ST; legal 1..32.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
mdc_rise_stb  input  1  one-cycle pulse, MDC rising edge next
mdc_fall_stb  input  1  one-cycle pulse, MDC falling edge next
req_valid  input  1  request present
req_ready  output  1  request accepted when valid&ready
req_write  input  1  1=write, 0=read
req_phy_addr  input  5  PHY address
req_reg_addr  input  5  register address
req_wdata  input  16  write data
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  16  read data (0 for writes)
rsp_err  output  1  read TA bit sampled as 1 (no PHY)
mdio_out  output  1  serial data to pad
mdio_tri  output  1  1=station drives pad, 0=released
mdio_in  input  1  pad input

Behaviour:
- Reset (reset=0, asynchronous):
  - req_ready=0 while asserted, 1 on the first cycle after release.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, mdio_out=0, mdio_tri=0.
  - State=IDLE, bit counter=0.
  - Reset mid-frame aborts immediately: bus released, no rsp_valid is produced.
- States: IDLE, WAIT, PRE, FRAME.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch all req_* fields and move to WAIT.
  - req_ready is 0 in every other state.
- WAIT: on the next mdc_fall_stb, drive mdio_out=1, mdio_tri=1, bit counter=0, move to PRE.
- PRE:
  - Each mdc_fall_stb increments the counter.
  - When the counter reaches PREAMBLE_LEN-1 and a fall strobe occurs, present frame bit 0, reset the counter, move to FRAME.
- FRAME: 32 bits, MSB first. One bit per MDC period, changed only on mdc_fall_stb. Layout:
  - ST=01.
  - OP=01 (write) or 10 (read).
  - PHYAD[4:0], REGAD[4:0].
  - TA: write=10; read=released.
  - DATA[15:0]: write=req_wdata; read=released.
- Drive control:
  - Writes: mdio_tri=1 for all 32 frame bits.
  - Reads: mdio_tri=1 for frame bits 0-13. mdio_tri=0 and mdio_out=0 from the fall strobe that would present bit 14 onward.
- Read sampling, on mdc_rise_stb only:
  - During frame bit 15: rsp_err <= mdio_in.
  - During bits 16-31: shift mdio_in into rsp_rdata, MSB first.
  - rsp_rdata/rsp_err hold their value until the next response.
- Completion:
  - The mdc_fall_stb ending bit 31 releases the bus (mdio_tri=0, mdio_out=0).
  - On the following cycle: rsp_valid=1 for exactly one cycle, state=IDLE, req_ready=1.
  - A write clears rsp_rdata=0 and rsp_err=0 at acceptance.
- Latency: preamble + frame = PREAMBLE_LEN+32 MDC periods, plus up to one MDC period in WAIT, plus 1 clk.
- Back-to-back: a new request may be accepted in the same cycle as rsp_valid. The next frame starts at the following fall strobe, so there is no idle bus bit beyond the WAIT alignment.
- Strobe edge cases:
  - Strobes arriving in IDLE are ignored.
  - If mdc_rise_stb and mdc_fall_stb coincide (illegal generator output), the fall advances the bit and the sample is discarded.
- Counter widths: preamble counter 5 bits, frame counter 5 bits. Terminal values are compared explicitly, with no reliance on wrap-around.

Test Plan:
- Write phy=1 reg=0 data=0x1140, PREAMBLE_LEN=32 -> pad shows 32 ones then 01 01 00001 00000 10 0001000101000000. mdio_tri=1 for all 64 bits. rsp_valid pulses once with rsp_err=0.
- Read phy=5 reg=2, PHY model drives TA=0 and data 0x0141 -> mdio_tri falls at frame bit 14. rsp_rdata=0x0141, rsp_err=0.
- Read with mdio_in pulled high (no PHY) -> rsp_rdata=0xFFFF, rsp_err=1, single rsp_valid.
- req_valid held high for two requests (write then read) -> req_ready=0 throughout frame 1. Second request accepted on the rsp_valid cycle. Both frames are correct, with at most one MDC period between them.
- Reset asserted at frame bit 20 of a read -> outputs drop asynchronously to reset values and no rsp_valid is seen. After release, a new write completes correctly.
- PREAMBLE_LEN=1 -> exactly one '1' precedes ST=01 and the total frame is 33 MDC periods.
